sha256_compress_ctrl: RTL

Sequencer for one SHA-256 compression: loads a 256-bit chaining state (midstate) and a 512-bit message block, then steps the round datapath (ch, maj, Σ0/Σ1, σ0/σ1, K-constant add) once per clock for 64 rounds. It finishes with the feed-forward add and presents the digest. It sits between the miner's nonce/header front end and the double-hash wrapper, which issues two compressions per nonce.

---
 rtl/sha256_pkg.sv | 45 ++++
 rtl/sha256_round.sv | 42 ++++
 rtl/sha256_compress_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, controller state encoding and bit-mixing helpers.
// Only the package lives here; the datapath and sequencing live in the modules.
package sha256_pkg;

   localparam int WORD_W     = 32;
   localparam int ROUNDS_STD = 64;
   localparam int RND_W      = 6;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [WORD_W-1:0] K [ROUNDS_STD] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round, purely combinational: working regs in, next working regs out.
// Zero latency; no flow control.
module sha256_round
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic [WORD_W-1:0] c,
   input  logic [WORD_W-1:0] d,
   input  logic [WORD_W-1:0] e,
   input  logic [WORD_W-1:0] f,
   input  logic [WORD_W-1:0] g,
   input  logic [WORD_W-1:0] h,
   input  logic [WORD_W-1:0] w,
   input  logic [WORD_W-1:0] k,
   output logic [WORD_W-1:0] next_a,
   output logic [WORD_W-1:0] next_b,
   output logic [WORD_W-1:0] next_c,
   output logic [WORD_W-1:0] next_d,
   output logic [WORD_W-1:0] next_e,
   output logic [WORD_W-1:0] next_f,
   output logic [WORD_W-1:0] next_g,
   output logic [WORD_W-1:0] next_h
);

   logic [WORD_W-1:0] ch, maj, t1, t2;

   assign ch  = (e & f) ^ (~e & g);
   assign maj = (a & b) ^ (a & c) ^ (b & c);
   assign t1  = h + big_sigma1(e) + ch + k + w;
   assign t2  = big_sigma0(a) + maj;

   assign next_a = t1 + t2;
   assign next_b = a;
   assign next_c = b;
   assign next_d = c;
   assign next_e = d + t1;
   assign next_f = e;
   assign next_g = f;
   assign next_h = g;

endmodule

// File: rtl/sha256_compress_ctrl.sv
// Sequences one SHA-256 compression: load, NUM_ROUNDS rounds, feed-forward; done NUM_ROUNDS+2 cycles after start.
// start is only sampled in IDLE; requests arriving while busy are dropped, not queued.
module sha256_compress_ctrl
   import sha256_pkg::*;
#(
   parameter int NUM_ROUNDS = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] midstate_in,
   input  logic [511:0] block_in,
   output logic         busy,
   output logic         done,
   output logic [255:0] digest_out
);

   state_t              state;
   logic [RND_W-1:0]    round;
   logic [255:0]        mid_r;
   logic [WORD_W-1:0]   a, b, c, d, e, f, g, h;
   logic [WORD_W-1:0]   na, nb, nc, nd, ne, nf, ng, nh;
   logic [WORD_W-1:0]   w [16];
   logic [WORD_W-1:0]   w_new;

   sha256_round u_round (
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
      .w(w[0]), .k(K[round]),
      .next_a(na), .next_b(nb), .next_c(nc), .next_d(nd),
      .next_e(ne), .next_f(nf), .next_g(ng), .next_h(nh)
   );

   // W[15] becomes W[t+16]; for t<16 the value is simply never consumed early.
   assign w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         round      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         digest_out <= '0;
         mid_r      <= '0;
         {a, b, c, d, e, f, g, h} <= '0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mid_r <= midstate_in;
                  {a, b, c, d, e, f, g, h} <= midstate_in;
                  for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
                  round <= '0;
                  busy  <= 1'b1;
                  state <= ROUND;
               end
            end
            ROUND: begin
               {a, b, c, d, e, f, g, h} <= {na, nb, nc, nd, ne, nf, ng, nh};
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_new;
               round <= round + 1'b1;
               if (round == RND_W'(NUM_ROUNDS - 1)) state <= FINAL;
            end
            FINAL: begin
               digest_out <= {mid_r[255:224] + a, mid_r[223:192] + b,
                              mid_r[191:160] + c, mid_r[159:128] + d,
                              mid_r[127:96]  + e, mid_r[95:64]   + f,
                              mid_r[63:32]   + g, mid_r[31:0]    + h};
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
